clpolydiv: RTL

Sequential carry-less (GF(2) polynomial) divider, the inverse of the Zbc carry-less multiply datapath: for dividend A and divisor B it produces Q and R such that clmul(Q, B) XOR R = A and deg(R) < deg(B). It sits beside the bit-manipulation unit in the integer execution stage. It serves as the polynomial-reduction engine for CRC/GCM-style sequences and as a checker for clmul results. It retires one quotient bit per cycle under a start/done handshake.

---
 rtl/clpolydiv.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/clpolydiv.sv
// -----------------------------------------------------------------------------
// clpolydiv -- sequential carry-less (GF(2) polynomial) divider.
//
// For dividend A and divisor B the block produces Q and R such that
// clmul(Q, B) ^ R == A and deg(R) < deg(B). One quotient bit is retired per
// clock, MSB first, so a division takes WIDTH cycles after acceptance.
//
// Ports:
//   clk      in   clock, rising edge
//   resetn   in   asynchronous active-low reset
//   Start    in   request, sampled only in IDLE or DONE
//   Flush    in   abort to IDLE, wins over Start
//   A        in   dividend, captured on the accepting edge
//   B        in   divisor, captured on the accepting edge
//   Busy     out  division in progress
//   Done     out  Q/R/DivZero valid
//   DivZero  out  captured divisor was zero (valid with Done)
//   Q        out  quotient
//   R        out  remainder
// -----------------------------------------------------------------------------
module clpolydiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             Start,
  input  logic             Flush,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] R
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Index of the most-significant set bit; 0 when the vector is zero.
  function automatic logic [CW-1:0] msb_index(input logic [WIDTH-1:0] v);
    logic [CW-1:0] idx;
    idx = {CW{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        idx = CW'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] qt_q, qt_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    deg_q, deg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] t_s;
  logic             fire_s;
  logic             accept_s;

  // Next-state logic: flush, accept, one division step, or hold.
  always_comb begin
    // Remainder shifted left with the next dividend bit brought in. Because
    // deg(r_q) < deg_q before every step, this never needs an extra bit.
    t_s      = {r_q[WIDTH-2:0], a_q[WIDTH-1]};
    // A zero divisor never subtracts, so R accumulates A and Q stays zero.
    fire_s   = (b_q != {WIDTH{1'b0}}) && t_s[deg_q];
    accept_s = Start && !Flush && ((state_q == S_IDLE) || (state_q == S_DONE));

    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    qt_d    = qt_q;
    cnt_d   = cnt_q;
    deg_d   = deg_q;
    dz_d    = dz_q;
    busy_d  = busy_q;
    done_d  = done_q;

    if (Flush) begin
      // Results are kept but marked invalid by Done dropping.
      state_d = S_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
    end else if (accept_s) begin
      state_d = S_BUSY;
      a_d     = A;
      b_d     = B;
      deg_d   = msb_index(B);
      r_d     = {WIDTH{1'b0}};
      qt_d    = {WIDTH{1'b0}};
      cnt_d   = {CW{1'b0}};
      dz_d    = (B == {WIDTH{1'b0}});
      busy_d  = 1'b1;
      done_d  = 1'b0;
    end else if (state_q == S_BUSY) begin
      r_d   = fire_s ? (t_s ^ b_q) : t_s;
      qt_d  = {qt_q[WIDTH-2:0], fire_s};
      a_d   = {a_q[WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + CNT_ONE;
      if (cnt_q == CNT_LAST) begin
        state_d = S_DONE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end else begin
        state_d = S_BUSY;
        busy_d  = 1'b1;
        done_d  = 1'b0;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      r_q     <= {WIDTH{1'b0}};
      qt_q    <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      deg_q   <= {CW{1'b0}};
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      qt_q    <= qt_d;
      cnt_q   <= cnt_d;
      deg_q   <= deg_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign Q       = qt_q;
  assign R       = r_q;

endmodule
